// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stream
//  Description : Read-side consumer of the asynchronous FIFO. Pops words from
//                the show-ahead read port into a 2-entry skid buffer and
//                presents them as a valid/ready stream with burst framing
//                (out_last) and a saturating transfer counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int DSIZE     = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic             flush,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] xfer_cnt
);

    // Beat counter width; a 1-bit counter that never leaves 0 covers BURST_LEN=1.
    localparam int              c_BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = {CNT_W{1'b1}};

    // Buffer occupancy doubles as the state encoding.
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_TWO   = 2'd2;

    logic [1:0]          r_count;
    logic [DSIZE-1:0]    r_head;
    logic [DSIZE-1:0]    r_tail;
    logic [c_BEAT_W-1:0] r_beat;
    logic [CNT_W-1:0]    r_xfer_cnt;

    logic w_push;
    logic w_pop;

    // Pop request depends only on registered occupancy and FIFO/control inputs,
    // never on out_ready, so backpressure cannot reach the FIFO pointer logic.
    always_comb begin
        rinc      = !rempty && (r_count != c_TWO) && !flush && rrst_n;
        w_push    = rinc;
        out_valid = (r_count != c_EMPTY);
        w_pop     = out_valid && out_ready;
        out_data  = r_head;
        out_last  = out_valid && (r_beat == c_BEAT_LAST);
        xfer_cnt  = r_xfer_cnt;
    end

    // Buffer occupancy, data entries, burst position and transfer counter.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_count    <= c_EMPTY;
            r_head     <= '0;
            r_tail     <= '0;
            r_beat     <= '0;
            r_xfer_cnt <= '0;
        end else begin
            // A transfer accepted in a flush cycle still counts.
            if (w_pop && (r_xfer_cnt != c_CNT_MAX)) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            end

            if (flush) begin
                // rinc is held low during flush, so nothing is taken from the FIFO.
                r_count <= c_EMPTY;
                r_beat  <= '0;
            end else begin
                if (w_pop) begin
                    r_beat <= (r_beat == c_BEAT_LAST) ? '0 : r_beat + c_BEAT_W'(1);
                end

                case (r_count)
                    c_EMPTY: begin
                        if (w_push) begin
                            r_head  <= rdata;
                            r_count <= c_ONE;
                        end
                    end
                    c_ONE: begin
                        if (w_push && w_pop) begin
                            r_head <= rdata;
                        end else if (w_push) begin
                            r_tail  <= rdata;
                            r_count <= c_TWO;
                        end else if (w_pop) begin
                            r_count <= c_EMPTY;
                        end
                    end
                    c_TWO: begin
                        // No push is possible here: rinc is low while full.
                        if (w_pop) begin
                            r_head  <= r_tail;
                            r_count <= c_ONE;
                        end
                    end
                    default: begin
                        r_count <= c_EMPTY;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer of the asynchronous FIFO. Runs entirely in the read clock domain.
- Pops words from the FIFO's show-ahead read port (rdata, rempty, rinc) into a 2-entry output buffer.
- Presents the words as a valid/ready stream with burst framing (out_last) and a transfer counter.
- Isolates downstream backpressure from rinc, so no combinational path runs from out_ready into the FIFO pointer logic.

Parameters:
- DSIZE, 8, data word width; must equal the FIFO DSIZE.
- BURST_LEN, 4, words per burst; out_last marks every BURST_LEN-th transfer; legal range 1..256.
- CNT_W, 16, width of the saturating transfer counter.

Ports:
- rclk  input  1  read-domain clock; all logic on its rising edge.
- rrst_n  input  1  reset, synchronous, active-low; sampled on posedge rclk.
- rdata  input  DSIZE  FIFO read data; valid whenever rempty=0 (show-ahead).
- rempty  input  1  FIFO empty flag; registered in the FIFO, high out of reset.
- rinc  output  1  FIFO pop request; the word on rdata is consumed on this rclk edge.
- flush  input  1  synchronous discard of buffered words and burst position.
- out_data  output  DSIZE  stream data (head of buffer).
- out_valid  output  1  stream valid.
- out_ready  input  1  downstream accept.
- out_last  output  1  high with out_valid on the final word of a burst.
- xfer_cnt  output  CNT_W  number of completed stream transfers, saturating.

Behaviour:
- Reset (rrst_n=0 at posedge rclk):
  - count=0; beat=0; xfer_cnt=0; both buffer entries zeroed.
  - out_valid=0, out_last=0, out_data=0, rinc=0.
  - Reset overrides flush and all handshakes.
- Buffer states, encoded in count:
  - EMPTY (0), ONE (1), TWO (2).
  - Entries are head and tail; out_data = head.
- rinc = !rempty && count<2 && !flush && rrst_n.
  - rinc is purely combinational from registered state and inputs; it never depends on out_ready.
- push = rinc: rdata is written into the buffer on that same edge.
- pop = out_valid && out_ready.
- out_valid = (count != 0).
- State transitions:
  - EMPTY + push -> ONE; data goes to head.
  - ONE + push, no pop -> TWO; data goes to tail.
  - ONE + pop, no push -> EMPTY.
  - ONE + push + pop -> ONE; head <= rdata (full throughput, 1 word/cycle).
  - TWO + pop -> ONE; head <= tail. push is impossible in TWO.
  - Any other combination holds state.
- Stability: out_data and out_last stay stable while out_valid=1 and out_ready=0.
- Latency: a word at the FIFO head with count=0 appears on out_valid/out_data one rclk after rinc.
- Burst framing:
  - beat is a 0..BURST_LEN-1 counter.
  - out_last = out_valid && (beat == BURST_LEN-1).
  - On pop: beat wraps to 0 if it was BURST_LEN-1, otherwise beat+1.
  - With BURST_LEN=1, out_last = out_valid.
- xfer_cnt increments by 1 on each pop and saturates at 2^CNT_W-1; no wrap.
- flush=1 at posedge:
  - count <= 0, beat <= 0; rinc is forced 0 that cycle, so no FIFO word is lost.
  - xfer_cnt is unaffected.
  - A pop coinciding with flush still counts in xfer_cnt; flush still empties the buffer.
- rempty toggling while count=2 has no effect until a slot frees.

Test Plan:
- Reset, then 5 words A0..A4 in FIFO, out_ready=1 -> out_data A0..A4 on 5 consecutive cycles after 1-cycle latency; rinc high 5 cycles; out_last on A3 only; xfer_cnt=5.
- FIFO holds 6 words, out_ready=0 -> rinc pulses exactly 2 cycles, count=2, out_data holds first word. Then raise out_ready -> all 6 delivered in order with no gaps or duplicates.
- out_ready toggling 1,0,1,0 with FIFO continuously non-empty -> order preserved; out_data stable on every stalled cycle; beat advances only on accepted words.
- Buffer at count=2 plus flush=1 with FIFO non-empty -> next cycle out_valid=0, rinc=0 during flush, beat=0, xfer_cnt unchanged. Next word delivered with beat 0.
- CNT_W=4, 20 transfers -> xfer_cnt stops at 15.
- rrst_n=0 asserted mid-burst at beat=2 -> next edge out_valid=0, rinc=0, beat=0, xfer_cnt=0. After release, the first word is beat 0.
